rs232_uart: RTL and testbench

Full-duplex 8N1 RS-232 serial port: a transmitter that requests, latches and serializes bytes, and a receiver that deserializes and validates bytes from an asynchronous line. It sits between the framing/escaping protocol engine and the board UART pins. It provides one byte-wide request/load handshake toward the engine on transmit and one byte-strobe on receive.

---
 rtl/rs232_pkg.sv | 29 ++
 rtl/rs232_bit_timer.sv | 41 ++++
 rtl/rs232_uart.sv | 190 +++++++++++++++++++
 tb/tb_rs232_uart.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rs232_pkg.sv
// Shared definitions for the rs232_uart serial port: default bit timing,
// transmit/receive FSM encodings and the protocol byte constants.
package rs232_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 434;

  localparam logic [7:0] FRAME_START = 8'h06;
  localparam logic [7:0] FRAME_END   = 8'h07;
  localparam logic [7:0] ESC_VAL     = 8'h14;
  localparam logic [7:0] OKAY        = 8'h05;
  localparam logic [7:0] ERROR       = 8'h04;

  typedef enum logic [2:0] {
    TX_IDLE  = 3'd0,
    TX_REQ   = 3'd1,
    TX_LATCH = 3'd2,
    TX_START = 3'd3,
    TX_DATA  = 3'd4,
    TX_STOP  = 3'd5
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/rs232_bit_timer.sv
// Bit-period down-counter: preloads a full or half bit and ticks on the last
// cycle of each period, then reloads a full bit by itself.
module rs232_bit_timer #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk_i,
  input  logic init_i,
  input  logic load_i,
  input  logic half_i,
  output logic tick_o
);

  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] FULL = W'(CLKS_PER_BIT - 1);
  localparam logic [W-1:0] HALF = W'(CLKS_PER_BIT / 2 - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tick_o = (cnt_q == {W{1'b0}});

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = half_i ? HALF : FULL;
    end else if (tick_o) begin
      cnt_d = FULL;
    end else begin
      cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i) begin
    if (init_i) begin
      cnt_q <= FULL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rs232_uart.sv
// Full-duplex 8N1 serial port with LOAD/DIN transmit handshake and STORE/DOUT
// receive strobe. Define RS232_STOP_CHECK_EN to drop frames with a bad stop bit.
module rs232_uart
  import rs232_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       CLK,
  input  logic       INIT,
  input  logic       DRL,
  input  logic [7:0] DIN,
  output logic       LOAD,
  output logic       TX,
  input  logic       RX,
  output logic       STORE,
  output logic [7:0] DOUT
);

  tx_state_t  tx_state_q, tx_state_d;
  logic [2:0] tx_bit_q, tx_bit_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic       tx_q, tx_d, load_q, load_d;
  logic       tx_tick;

  rx_state_t  rx_state_q, rx_state_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] dout_q, dout_d;
  logic       store_q, store_d;
  logic       rx_s1_q, rx_s2_q, rx_prev_q;
  logic       rx_tick, rx_fall, rx_tmr_load;

  assign TX    = tx_q;
  assign LOAD  = load_q;
  assign STORE = store_q;
  assign DOUT  = dout_q;

  // The bit period restarts in LATCH so the start bit is always full length.
  rs232_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
    .clk_i(CLK), .init_i(INIT), .load_i(tx_state_q == TX_LATCH),
    .half_i(1'b0), .tick_o(tx_tick)
  );

  always_ff @(posedge CLK) begin
    if (INIT) begin
      tx_state_q <= TX_IDLE;
      tx_bit_q   <= 3'd0;
      tx_shift_q <= 8'h00;
      tx_q       <= 1'b1;
      load_q     <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
      load_q     <= load_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    case (tx_state_q)
      TX_IDLE:  tx_state_d = DRL ? TX_REQ : TX_IDLE;
      TX_REQ:   tx_state_d = TX_LATCH;
      TX_LATCH: begin
        tx_shift_d = DIN;
        tx_bit_d   = 3'd0;
        tx_state_d = TX_START;
      end
      TX_START: tx_state_d = tx_tick ? TX_DATA : TX_START;
      TX_DATA: begin
        if (tx_tick) begin
          tx_shift_d = {1'b1, tx_shift_q[7:1]};
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TX_STOP;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
          end
        end else begin
          tx_state_d = TX_DATA;
        end
      end
      TX_STOP: begin
        if (tx_tick) begin
          tx_state_d = DRL ? TX_REQ : TX_IDLE;
        end else begin
          tx_state_d = TX_STOP;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // Outputs decoded from the next state so TX and LOAD come straight from flops.
  always_comb begin
    load_d = (tx_state_d == TX_REQ);
    case (tx_state_d)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = tx_shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  assign rx_fall     = rx_prev_q & ~rx_s2_q;
  assign rx_tmr_load = (rx_state_q == RX_IDLE) && rx_fall;

  rs232_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
    .clk_i(CLK), .init_i(INIT), .load_i(rx_tmr_load),
    .half_i(1'b1), .tick_o(rx_tick)
  );

  always_ff @(posedge CLK) begin
    if (INIT) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'h00;
      dout_q     <= 8'h00;
      store_q    <= 1'b0;
    end else begin
      rx_s1_q    <= RX;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      dout_q     <= dout_d;
      store_q    <= store_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    case (rx_state_q)
      RX_IDLE:  rx_state_d = rx_fall ? RX_START : RX_IDLE;
      RX_START: begin
        if (rx_tick) begin
          rx_bit_d   = 3'd0;
          rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_state_d = RX_START;
        end
      end
      RX_DATA: begin
        if (rx_tick) begin
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_state_d = RX_DATA;
        end
      end
      RX_STOP:  rx_state_d = rx_tick ? RX_IDLE : RX_STOP;
      default:  rx_state_d = RX_IDLE;
    endcase
  end

  // After a bad stop bit, IDLE re-arms only on a fresh high-to-low edge.
  always_comb begin
    store_d = 1'b0;
    dout_d  = dout_q;
    if ((rx_state_q == RX_STOP) && rx_tick) begin
`ifdef RS232_STOP_CHECK_EN
      if (rx_s2_q) begin
        store_d = 1'b1;
        dout_d  = rx_shift_q;
      end else begin
        store_d = 1'b0;
        dout_d  = dout_q;
      end
`else
      store_d = 1'b1;
      dout_d  = rx_shift_q;
`endif
    end else begin
      store_d = 1'b0;
      dout_d  = dout_q;
    end
  end

endmodule

// File: tb/tb_rs232_uart.sv
// Self-checking bench for rs232_uart at 8 clocks per bit: TX waveforms are
// predicted from frame arithmetic, RX bytes from a queue of sent frames.
module tb_rs232_uart;
  import rs232_pkg::*;

  localparam int CPB = 8;
  localparam int P   = 10 * CPB + 2;
  localparam int NOM = 2 + CPB / 2 + 9 * CPB;

  logic       CLK = 1'b0;
  logic       INIT = 1'b1;
  logic       DRL = 1'b0;
  logic       RX = 1'b1;
  logic [7:0] DIN = 8'h00;
  logic       LOAD, TX, STORE;
  logic [7:0] DOUT;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] tx_bytes [4];
  int         tx_n;
  logic [7:0] rx_exp [$];
  int         rx_fall [$];
  logic [7:0] rx_got [$];
  int         rx_got_cyc [$];
  logic       prev_store = 1'b0;

  rs232_uart #(.CLKS_PER_BIT(CPB)) dut (
    .CLK(CLK), .INIT(INIT), .DRL(DRL), .DIN(DIN), .LOAD(LOAD),
    .TX(TX), .RX(RX), .STORE(STORE), .DOUT(DOUT)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Receive monitor: collects every STORE and flags back-to-back strobes.
  initial begin
    forever begin
      @(negedge CLK);
      if (STORE) begin
        check_eq("store_gap", 32'(prev_store), 32'd0);
        rx_got.push_back(DOUT);
        rx_got_cyc.push_back(cyc);
      end
      prev_store = STORE;
    end
  end

  function automatic logic exp_tx(input int c);
    int off, k, r, bp;
    logic [7:0] b;
    if (c < 3) return 1'b1;
    off = c - 3;
    k   = off / P;
    r   = off % P;
    if (k >= tx_n || r >= 10 * CPB) return 1'b1;
    bp = r / CPB;
    if (bp == 0) return 1'b0;
    if (bp == 9) return 1'b1;
    b = tx_bytes[k];
    return b[bp - 1];
  endfunction

  function automatic logic exp_load(input int c);
    return (c >= 1) && ((c - 1) % P == 0) && ((c - 1) / P < tx_n);
  endfunction

  // Holds DRL until the last LOAD, answers each LOAD with the next byte.
  task automatic run_tx(input string tag);
    int loads = 0;
    int len = 3 + tx_n * P + 16;
    for (int c = 0; c < len; c++) begin
      check_eq({tag, "_load"}, 32'(LOAD), 32'(exp_load(c)));
      check_eq({tag, "_tx"}, 32'(TX), 32'(exp_tx(c)));
      if (LOAD) begin
        loads++;
        DIN = tx_bytes[(loads <= tx_n) ? loads - 1 : tx_n - 1];
      end
      DRL = (loads < tx_n);
      wait_cycles(1);
    end
    DRL = 1'b0;
    check_eq({tag, "_load_count"}, 32'(loads), 32'(tx_n));
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    logic valid;
`ifdef RS232_STOP_CHECK_EN
    valid = stop_bit;
`else
    valid = 1'b1;
`endif
    if (valid) begin
      rx_exp.push_back(b);
      rx_fall.push_back(cyc);
    end
    RX = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      wait_cycles(CPB);
    end
    RX = stop_bit;
    wait_cycles(CPB);
    RX = 1'b1;
  endtask

  task automatic rx_compare(input string tag);
    int n, lat;
    check_eq({tag, "_count"}, 32'(rx_got.size()), 32'(rx_exp.size()));
    n = (rx_got.size() < rx_exp.size()) ? rx_got.size() : rx_exp.size();
    for (int i = 0; i < n; i++) begin
      check_eq({tag, "_byte"}, 32'(rx_got[i]), 32'(rx_exp[i]));
      lat = rx_got_cyc[i] - rx_fall[i];
      check_eq($sformatf("%s_latency_%0d_within_%0d+-1", tag, lat, NOM),
               32'((lat >= NOM - 1) && (lat <= NOM + 1)), 32'd1);
    end
    rx_exp.delete();
    rx_fall.delete();
    rx_got.delete();
    rx_got_cyc.delete();
  endtask

  initial begin
    logic [7:0] ib;
    @(posedge CLK);
    #1;
    wait_cycles(3);
    check_eq("rst_tx", 32'(TX), 32'd1);
    check_eq("rst_load", 32'(LOAD), 32'd0);
    check_eq("rst_store", 32'(STORE), 32'd0);
    check_eq("rst_dout", 32'(DOUT), 32'h00);
    INIT = 1'b0;
    wait_cycles(2);

    tx_n = 1;
    tx_bytes[0] = FRAME_START;
    DIN = 8'hFF;
    run_tx("tx_single");

    tx_n = 3;
    tx_bytes[0] = FRAME_START;
    tx_bytes[1] = ESC_VAL;
    tx_bytes[2] = FRAME_END;
    run_tx("tx_b2b");

    tx_n = 3;
    for (int i = 0; i < 3; i++) tx_bytes[i] = 8'($urandom);
    DIN = 8'($urandom);
    run_tx("tx_rand");

    send_rx(8'hA5, 1'b1);
    send_rx(8'h3C, 1'b1);
    wait_cycles(2 * CPB);
    rx_compare("rx_pair");
    check_eq("rx_dout_hold", 32'(DOUT), 32'h3C);

    RX = 1'b0;
    wait_cycles(2);
    RX = 1'b1;
    wait_cycles(4 * CPB);
    rx_compare("rx_glitch");
    send_rx(8'($urandom), 1'b1);
    wait_cycles(2 * CPB);
    rx_compare("rx_after_glitch");

    send_rx(8'h55, 1'b0);
    wait_cycles(2 * CPB);
    send_rx(8'($urandom), 1'b1);
    wait_cycles(2 * CPB);
    rx_compare("rx_stop_bit");

    for (int i = 0; i < 6; i++) begin
      send_rx(8'($urandom), 1'b1);
      wait_cycles(int'($urandom_range(0, 3)));
    end
    wait_cycles(2 * CPB);
    rx_compare("rx_rand");

    tx_n = 2;
    for (int i = 0; i < 2; i++) tx_bytes[i] = 8'($urandom);
    fork
      run_tx("duplex_tx");
      begin
        send_rx(8'($urandom), 1'b1);
        send_rx(8'($urandom), 1'b1);
      end
    join
    wait_cycles(2 * CPB);
    rx_compare("duplex_rx");

    // INIT in the middle of data bit 3 of an outgoing frame.
    ib = 8'hA5;
    DIN = ib;
    DRL = 1'b1;
    wait_cycles(1);
    check_eq("init_pre_load", 32'(LOAD), 32'd1);
    DRL = 1'b0;
    wait_cycles(37);
    check_eq("init_pre_tx_bit3", 32'(TX), 32'(ib[3]));
    INIT = 1'b1;
    wait_cycles(1);
    check_eq("init_tx", 32'(TX), 32'd1);
    check_eq("init_load", 32'(LOAD), 32'd0);
    check_eq("init_store", 32'(STORE), 32'd0);
    check_eq("init_dout", 32'(DOUT), 32'h00);
    INIT = 1'b0;
    for (int i = 0; i < 3 * CPB; i++) begin
      wait_cycles(1);
      check_eq("init_idle_tx", 32'(TX), 32'd1);
      check_eq("init_idle_load", 32'(LOAD), 32'd0);
    end
    DRL = 1'b1;
    wait_cycles(1);
    check_eq("init_rearm_load", 32'(LOAD), 32'd1);
    DRL = 1'b0;
    wait_cycles(12 * CPB);
    check_eq("end_store_count", 32'(rx_got.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
